seg7_scan_driver: RTL and testbench

Parametrised multiplexed 7-segment scanner that generalises the existing fixed 4-digit display control to N digits. It takes packed hex/BCD nibbles, decimal points and per-digit masks from upstream logic (bin2bcd, state machine). It drives time-multiplexed active-low anodes and segments with an anti-ghosting blank interval, frame-coherent data loading, leading-zero suppression and per-digit blinking. It sits between the application datapath and the board's seg/an/dp pins.

---
 rtl/seg7_pkg.sv | 25 ++
 rtl/seg7_hex_decode.sv | 32 +++
 rtl/seg7_scan_driver.sv | 166 ++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment constants
package seg7_pkg;

  localparam int MAX_DIGITS = 8;

  // Active-low segment patterns in [0:6] = a..g order
  localparam logic [0:6] SEG_NULL = 7'b1111111;
  localparam logic [0:6] SEG_0    = 7'b0000001;
  localparam logic [0:6] SEG_1    = 7'b1001111;
  localparam logic [0:6] SEG_2    = 7'b0010010;
  localparam logic [0:6] SEG_3    = 7'b0000110;
  localparam logic [0:6] SEG_4    = 7'b1001100;
  localparam logic [0:6] SEG_5    = 7'b0100100;
  localparam logic [0:6] SEG_6    = 7'b0100000;
  localparam logic [0:6] SEG_7    = 7'b0001111;
  localparam logic [0:6] SEG_8    = 7'b0000000;
  localparam logic [0:6] SEG_9    = 7'b0000100;
  localparam logic [0:6] SEG_A    = 7'b0001000;
  localparam logic [0:6] SEG_B    = 7'b1100000;
  localparam logic [0:6] SEG_C    = 7'b0110001;
  localparam logic [0:6] SEG_D    = 7'b1000010;
  localparam logic [0:6] SEG_E    = 7'b0110000;
  localparam logic [0:6] SEG_F    = 7'b0111000;

endpackage

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational nibble to active-low segment decoder
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [0:6] seg
);

  always_comb begin
    seg = SEG_NULL;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_NULL;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - N-digit multiplexed 7-segment scanner with blanking, blink and zero suppression
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS      = 8,
  parameter int TICKS_PER_DIGIT = 100_000,
  parameter int BLANK_TICKS     = 1_000,
  parameter int BLINK_FRAMES    = 32
) (
  input  logic                    clk_100MHz,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lz_suppress,
  input  logic                    load,
  output logic                    frame_start,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [0:6]              seg,
  output logic                    dp
);

  localparam int TW = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [TW-1:0] TIMER_LAST = TW'(TICKS_PER_DIGIT - 1);
  localparam logic [TW-1:0] BLANK_LIM  = TW'(BLANK_TICKS);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [TW-1:0]           timer;
  logic [IW-1:0]           idx;
  logic [FW-1:0]           frame_cnt;
  logic                    blink_phase;

  logic [4*NUM_DIGITS-1:0] stg_digits, dsp_digits, cur_digits;
  logic [NUM_DIGITS-1:0]   stg_dp, dsp_dp, cur_dp;
  logic [NUM_DIGITS-1:0]   stg_blank, dsp_blank, cur_blank;
  logic [NUM_DIGITS-1:0]   stg_blink, dsp_blink, cur_blink;
  logic                    stg_lz, dsp_lz, cur_lz;

  logic                    boundary, frame_wrap, phase_now, in_blank, above_clear;
  logic [3:0]              nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   lz_dark, dark;
  logic [3:0]              nib_sel;
  logic [0:6]              dec_seg;
  logic [NUM_DIGITS-1:0]   an_next;
  logic [0:6]              seg_next;
  logic                    dp_next;

  assign boundary   = (timer == '0) && (idx == '0);
  assign frame_wrap = (frame_cnt == FRAME_LAST);
  assign in_blank   = (BLANK_TICKS > 0) && (timer < BLANK_LIM);

  // At the frame boundary the snapshot being latched is already what this cycle shows
  always_comb begin
    cur_digits = dsp_digits;
    cur_dp     = dsp_dp;
    cur_blank  = dsp_blank;
    cur_blink  = dsp_blink;
    cur_lz     = dsp_lz;
    phase_now  = blink_phase;
    if (boundary) begin
      if (load) begin
        cur_digits = digits_in;
        cur_dp     = dp_in;
        cur_blank  = blank_mask;
        cur_blink  = blink_mask;
        cur_lz     = lz_suppress;
      end else begin
        cur_digits = stg_digits;
        cur_dp     = stg_dp;
        cur_blank  = stg_blank;
        cur_blink  = stg_blink;
        cur_lz     = stg_lz;
      end
      if (frame_wrap) phase_now = ~blink_phase;
    end
  end

  // Walk from the most significant digit down, tracking whether everything above is zero or blanked
  always_comb begin
    above_clear = 1'b1;
    lz_dark     = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      nib[k]     = cur_digits[4*k +: 4];
      lz_dark[k] = cur_lz && (nib[k] == 4'h0) && (k != 0) && above_clear;
      above_clear = above_clear && ((nib[k] == 4'h0) || cur_blank[k]);
    end
  end

  assign dark    = cur_blank | (cur_blink & {NUM_DIGITS{phase_now}}) | lz_dark;
  assign nib_sel = nib[idx];

  seg7_hex_decode u_dec (
    .nibble (nib_sel),
    .seg    (dec_seg)
  );

  always_comb begin
    an_next  = '1;
    seg_next = SEG_NULL;
    dp_next  = 1'b1;
    if (!in_blank && !dark[idx]) begin
      an_next  = ~(NUM_DIGITS'(1) << idx);
      seg_next = dec_seg;
      dp_next  = ~cur_dp[idx];
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      timer       <= '0;
      idx         <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      stg_digits  <= '0;
      stg_dp      <= '0;
      stg_blank   <= '0;
      stg_blink   <= '0;
      stg_lz      <= 1'b0;
      dsp_digits  <= '0;
      dsp_dp      <= '0;
      dsp_blank   <= '0;
      dsp_blink   <= '0;
      dsp_lz      <= 1'b0;
      frame_start <= 1'b0;
      an          <= '1;
      seg         <= SEG_NULL;
      dp          <= 1'b1;
    end else begin
      if (timer == TIMER_LAST) begin
        timer <= '0;
        idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        timer <= timer + 1'b1;
      end

      if (load) begin
        stg_digits <= digits_in;
        stg_dp     <= dp_in;
        stg_blank  <= blank_mask;
        stg_blink  <= blink_mask;
        stg_lz     <= lz_suppress;
      end

      if (boundary) begin
        dsp_digits  <= cur_digits;
        dsp_dp      <= cur_dp;
        dsp_blank   <= cur_blank;
        dsp_blink   <= cur_blink;
        dsp_lz      <= cur_lz;
        blink_phase <= phase_now;
        frame_cnt   <= frame_wrap ? '0 : frame_cnt + 1'b1;
      end

      frame_start <= boundary;
      an          <= an_next;
      seg         <= seg_next;
      dp          <= dp_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

  localparam int N  = 4;
  localparam int T  = 10;
  localparam int B  = 2;
  localparam int BF = 2;

  logic          clk_100MHz = 1'b0;
  logic          reset;
  logic [4*N-1:0] digits_in;
  logic [N-1:0]  dp_in, blank_mask, blink_mask;
  logic          lz_suppress, load;
  logic          frame_start;
  logic [N-1:0]  an;
  logic [0:6]    seg;
  logic          dp;

  seg7_scan_driver #(
    .NUM_DIGITS      (N),
    .TICKS_PER_DIGIT (T),
    .BLANK_TICKS     (B),
    .BLINK_FRAMES    (BF)
  ) dut (
    .clk_100MHz  (clk_100MHz),
    .reset       (reset),
    .digits_in   (digits_in),
    .dp_in       (dp_in),
    .blank_mask  (blank_mask),
    .blink_mask  (blink_mask),
    .lz_suppress (lz_suppress),
    .load        (load),
    .frame_start (frame_start),
    .an          (an),
    .seg         (seg),
    .dp          (dp)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  typedef struct {
    logic [15:0]     d;
    logic [3:0]      dpm;
    logic [3:0]      blank;
    logic            lz;
    logic [3:0]      lit;
    logic [3:0][6:0] seg;
  } vec_t;

  exp_t sb[$];
  vec_t vt[8];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   fcyc     = 0;

  task automatic tick();
    @(posedge clk_100MHz);
    #1;
    cyc++;
  endtask

  task automatic check_val(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic push(input logic [3:0] a, input logic [6:0] s, input logic d);
    exp_t e;
    e.an = a; e.seg = s; e.dp = d;
    sb.push_back(e);
  endtask

  task automatic push_slot(input vec_t v, input int k);
    if (v.lit[k]) push(~(4'b0001 << k), v.seg[k], ~v.dpm[k]);
    else          push(4'hF, 7'h7F, 1'b1);
  endtask

  task automatic check_out(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      $display("FAIL %s: scoreboard empty, got an=%b seg=%b dp=%b required an entry", name, an, seg, dp);
    end else begin
      e = sb.pop_front();
      check_val(name, {4'h0, an, seg, dp}, {4'h0, e.an, e.seg, e.dp});
    end
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    tick();
    while (frame_start !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    n_checks++;
    if (frame_start === 1'b1) n_pass++;
    else $display("FAIL wait_frame: frame_start=%b after %0d cycles, required 1", frame_start, n);
    fcyc = cyc;
  endtask

  task automatic goto(input int off);
    while (cyc - fcyc < off) tick();
  endtask

  task automatic check_frame(input string name);
    for (int k = 0; k < N; k++) begin
      goto(10 * k + 5);
      check_out($sformatf("%s_slot%0d", name, k));
    end
  endtask

  task automatic load_vec(input vec_t v);
    digits_in   = v.d;
    dp_in       = v.dpm;
    blank_mask  = v.blank;
    blink_mask  = 4'b0000;
    lz_suppress = v.lz;
    load        = 1'b1;
    tick();
    load        = 1'b0;
    for (int k = 0; k < N; k++) push_slot(v, k);
  endtask

  initial begin
    vec_t z;
    vt[0] = '{d:16'h12AF, dpm:4'b0100, blank:4'b0000, lz:1'b0, lit:4'b1111,
              seg:{7'b1001111, 7'b0010010, 7'b0001000, 7'b0111000}};
    vt[1] = '{d:16'h0050, dpm:4'b0000, blank:4'b0000, lz:1'b1, lit:4'b0011,
              seg:{7'h7F, 7'h7F, 7'b0100100, 7'b0000001}};
    vt[2] = '{d:16'h0000, dpm:4'b0000, blank:4'b0000, lz:1'b1, lit:4'b0001,
              seg:{7'h7F, 7'h7F, 7'h7F, 7'b0000001}};
    vt[3] = '{d:16'h0307, dpm:4'b0000, blank:4'b1000, lz:1'b1, lit:4'b0111,
              seg:{7'h7F, 7'b0000110, 7'b0000001, 7'b0001111}};
    vt[4] = '{d:16'h0B0C, dpm:4'b1111, blank:4'b0100, lz:1'b1, lit:4'b0001,
              seg:{7'h7F, 7'h7F, 7'h7F, 7'b0110001}};
    vt[5] = '{d:16'h6E4D, dpm:4'b0001, blank:4'b1000, lz:1'b0, lit:4'b0111,
              seg:{7'h7F, 7'b0110000, 7'b1001100, 7'b1000010}};
    vt[6] = '{d:16'h3579, dpm:4'b1000, blank:4'b0000, lz:1'b0, lit:4'b1111,
              seg:{7'b0000110, 7'b0100100, 7'b0001111, 7'b0000100}};
    vt[7] = '{d:16'h8600, dpm:4'b0000, blank:4'b0000, lz:1'b1, lit:4'b1111,
              seg:{7'b0000000, 7'b0100000, 7'b0000001, 7'b0000001}};
    z = '{d:16'h0000, dpm:4'b0000, blank:4'b0000, lz:1'b0, lit:4'b1111,
          seg:{7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001}};

    reset = 1'b1; load = 1'b0; digits_in = '0; dp_in = '0;
    blank_mask = '0; blink_mask = '0; lz_suppress = 1'b0;
    repeat (3) tick();
    check_val("in_reset", {4'h0, an, seg, dp, frame_start}, {4'h0, 4'hF, 7'h7F, 1'b1, 1'b0});

    // Release: cycles 0-2 dark, 3-10 digit 0, 11-12 blank, 13 digit 1
    for (int c = 0; c < 14; c++) begin
      if (c < 3 || c == 11 || c == 12) push(4'hF, 7'h7F, 1'b1);
      else if (c < 11)                 push(4'hE, 7'b0000001, 1'b1);
      else                             push(4'hD, 7'b0000001, 1'b1);
    end
    reset = 1'b0;
    for (int c = 0; c < 14; c++) begin
      if (c > 0) tick();
      check_out($sformatf("release_c%0d", c));
      if (c == 1) begin
        check_val("first_frame_start", {15'h0, frame_start}, 16'h1);
        fcyc = cyc;
      end
    end
    goto(39);
    check_val("frame_start_c39", {15'h0, frame_start}, 16'h0);
    goto(40);
    check_val("frame_start_c40", {15'h0, frame_start}, 16'h1);

    for (int i = 0; i < 8; i++) begin
      load_vec(vt[i]);
      wait_frame();
      check_frame($sformatf("vec%0d", i));
    end

    // Load during slot 2: rest of this frame keeps old snapshot
    wait_frame();
    goto(21);
    push_slot(vt[7], 2);
    push_slot(vt[7], 3);
    load_vec(vt[0]);
    goto(25); check_out("midload_old_slot2");
    goto(35); check_out("midload_old_slot3");
    wait_frame();
    check_frame("midload_new");

    // Reset inside digit 2 slot clears everything
    wait_frame();
    goto(25);
    reset = 1'b1;
    tick();
    push(4'hF, 7'h7F, 1'b1);
    check_out("reset_abort");
    check_val("reset_abort_fs", {15'h0, frame_start}, 16'h0);
    tick();
    reset = 1'b0;
    tick();
    check_val("restart_frame_start", {15'h0, frame_start}, 16'h1);
    fcyc = cyc;
    for (int k = 0; k < N; k++) push_slot(z, k);
    check_frame("after_reset");

    // Blink with load coincident with the first frame boundary after reset
    reset = 1'b1;
    repeat (2) tick();
    digits_in = 16'h0008; dp_in = 4'b0000; blank_mask = 4'b0000;
    blink_mask = 4'b0001; lz_suppress = 1'b0;
    reset = 1'b0;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    check_val("blink_frame_start", {15'h0, frame_start}, 16'h1);
    fcyc = cyc;
    for (int b = 1; b <= 6; b++) begin
      if (b > 1) wait_frame();
      if (((b / BF) % 2) == 0) push(4'hE, 7'b0000000, 1'b1);
      else                     push(4'hF, 7'h7F, 1'b1);
      goto(5);
      check_out($sformatf("blink_f%0d", b));
      if (b == 2) begin
        push(4'hD, 7'b0000001, 1'b1);
        goto(15);
        check_out("blink_other_digit");
      end
    end

    check_val("scoreboard_drained", 16'(sb.size()), 16'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
